// File: rtl/axis_decimating_averager.sv
// Block-mean decimator: averages 2^dec_log2 input samples into one AXIS result, 1-cycle latency after the final sample.
// The input is never stalled; a result that meets a stalled, full output register is dropped and counted. AXIS_DEC_ROUND_EN selects round-half-up.
module axis_decimating_averager #(
    parameter int S_AXIS_DATA_WIDTH = 32,
    parameter int M_AXIS_DATA_WIDTH = 32,
    parameter int DEC_LOG2_MAX      = 8
) (
    input  logic                                aclk,
    input  logic                                reset,
    input  logic signed [S_AXIS_DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                                S_AXIS_tvalid,
    input  logic [3:0]                          dec_log2,
    output logic signed [M_AXIS_DATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                                M_AXIS_tvalid,
    input  logic                                M_AXIS_tready,
    output logic [15:0]                         overrun_count
);
    localparam int ACC_W = S_AXIS_DATA_WIDTH + DEC_LOG2_MAX;
    localparam int CNT_W = DEC_LOG2_MAX + 1;
    localparam logic [3:0] DL_MAX = 4'(DEC_LOG2_MAX);

    typedef enum logic {EMPTY, FULL} ostate_e;

    logic signed [ACC_W-1:0]             acc_q, acc_d, sum, shifted;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [3:0]                          dl_q, dl_d, dl_in, dl_eff;
    logic                                blk_end;
    logic signed [M_AXIS_DATA_WIDTH-1:0] res, data_q, data_d;
    logic [15:0]                         ovr_q, ovr_d;
    ostate_e                             state_q, state_d;
`ifdef AXIS_DEC_ROUND_EN
    logic signed [ACC_W-1:0]             rnd, sum_r;
`endif

    // Accumulator and block counter; the first sample of a block uses the freshly latched exponent.
    always_comb begin
        dl_in   = (dec_log2 > DL_MAX) ? DL_MAX : dec_log2;
        dl_eff  = (cnt_q == '0) ? dl_in : dl_q;
        sum     = acc_q + ACC_W'(S_AXIS_tdata);
        blk_end = S_AXIS_tvalid && ((cnt_q + CNT_W'(1)) == (CNT_W'(1) << dl_eff));
`ifdef AXIS_DEC_ROUND_EN
        rnd     = (dl_eff == 4'd0) ? '0 : (ACC_W'(1) << (dl_eff - 4'd1));
        sum_r   = sum + rnd;
        shifted = sum_r >>> dl_eff;
`else
        shifted = sum >>> dl_eff;
`endif
        res     = M_AXIS_DATA_WIDTH'(shifted);
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dl_d    = dl_q;
        if (S_AXIS_tvalid) begin
            if (cnt_q == '0) begin
                dl_d = dl_in;
            end
            if (blk_end) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // One-deep output register; a simultaneous drain and load keeps it full without an overrun.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ovr_d   = ovr_q;
        if (state_q == EMPTY) begin
            if (blk_end) begin
                data_d  = res;
                state_d = FULL;
            end
        end else if (M_AXIS_tready) begin
            if (blk_end) begin
                data_d = res;
            end else begin
                state_d = EMPTY;
            end
        end else if (blk_end && (ovr_q != 16'hFFFF)) begin
            ovr_d = ovr_q + 16'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            dl_q    <= '0;
            data_q  <= '0;
            ovr_q   <= '0;
            state_q <= EMPTY;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dl_q    <= dl_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
            state_q <= state_d;
        end
    end

    assign M_AXIS_tvalid = (state_q == FULL);
    assign M_AXIS_tdata  = data_q;
    assign overrun_count = ovr_q;

endmodule
